// File: rtl/bilinear_job_sequencer.sv
// bilinear_job_sequencer
//   Host-side job controller for bilinear_top. Descriptors are queued in a
//   small FIFO and run one at a time. Each descriptor is validated, then
//   programmed over the CSR port (SCALE_Q, IN_W_H, OUT_W_H, CTRL). The
//   controller polls STATUS until the job is done, times out or is aborted,
//   then reads PERF_CYC/PERF_PIX, disables the core and presents one result
//   record that is held until it is accepted.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   job_valid/job_ready         descriptor handshake (ready = FIFO not full)
//   job_tag/mode/scale_q/...    descriptor fields
//   abort                       abort the in-flight job (WAIT states only)
//   res_valid/res_ready         result handshake
//   res_tag/err/cycles/pixels   result record
//   seq_busy                    FSM active or descriptors pending
//   stat_jobs                   count of jobs finished without error
//   csr_we/addr/wdata/rdata     CSR master port to bilinear_top
module bilinear_job_sequencer #(
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [TAG_W-1:0] job_tag,
  input  logic             job_mode,
  input  logic [15:0]      job_scale_q,
  input  logic [15:0]      job_in_w,
  input  logic [15:0]      job_in_h,
  input  logic [15:0]      job_out_w,
  input  logic [15:0]      job_out_h,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_err,
  output logic [31:0]      res_cycles,
  output logic [31:0]      res_pixels,
  output logic             seq_busy,
  output logic [15:0]      stat_jobs,
  output logic             csr_we,
  output logic [3:0]       csr_addr,
  output logic [31:0]      csr_wdata,
  input  logic [31:0]      csr_rdata
);

  localparam int unsigned PW = $clog2(QDEPTH);

  localparam logic [3:0] A_CTRL    = 4'd0;
  localparam logic [3:0] A_STATUS  = 4'd1;
  localparam logic [3:0] A_SCALE   = 4'd2;
  localparam logic [3:0] A_IN_WH   = 4'd3;
  localparam logic [3:0] A_OUT_WH  = 4'd4;
  localparam logic [3:0] A_PERF_C  = 4'd5;
  localparam logic [3:0] A_PERF_P  = 4'd6;

  localparam logic [1:0] E_OK      = 2'd0;
  localparam logic [1:0] E_BAD     = 2'd1;
  localparam logic [1:0] E_TMO     = 2'd2;
  localparam logic [1:0] E_ABORT   = 2'd3;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             mode;
    logic [15:0]      scale;
    logic [15:0]      in_w;
    logic [15:0]      in_h;
    logic [15:0]      out_w;
    logic [15:0]      out_h;
  } desc_t;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_WR_SCALE, S_WR_IN, S_WR_OUT, S_WR_CTRL,
    S_WAIT_BUSY, S_WAIT_DONE, S_RD_CYC, S_RD_PIX, S_DISABLE, S_RESULT
  } state_t;

  // ---------------------------------------------------------------- FIFO
  desc_t         mem_q [QDEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full, push, pop;
  desc_t         desc_in;

  assign desc_in    = '{tag: job_tag, mode: job_mode, scale: job_scale_q,
                        in_w: job_in_w, in_h: job_in_h,
                        out_w: job_out_w, out_h: job_out_h};
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign job_ready  = !fifo_full;
  assign push       = job_valid && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= desc_in;
  end

  // ---------------------------------------------------------------- FSM
  state_t        state_q, state_d;
  desc_t         job_q, job_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [31:0]   pix_q, pix_d;
  logic [31:0]   ctr_q, ctr_d;
  logic [15:0]   stat_q, stat_d;
  // Low only while in reset and the first cycle after, so csr_addr reads 0
  // under reset instead of the idle STATUS poll address.
  logic          init_q;
  logic          bad_desc, tmo_hit, st_busy, st_done;

  assign bad_desc = (job_q.in_w == 16'd0) || (job_q.in_h == 16'd0) ||
                    (job_q.out_w == 16'd0) || (job_q.out_h == 16'd0) ||
                    (job_q.out_w > job_q.in_w) || (job_q.out_h > job_q.in_h) ||
                    (job_q.scale == 16'd0);
  assign tmo_hit  = (TIMEOUT_CYC != 0) && (ctr_q == TIMEOUT_CYC);
  assign st_busy  = csr_rdata[0];
  assign st_done  = csr_rdata[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      job_q   <= '0;
      err_q   <= '0;
      cyc_q   <= '0;
      pix_q   <= '0;
      ctr_q   <= '0;
      stat_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      pix_q   <= pix_d;
      ctr_q   <= ctr_d;
      stat_q  <= stat_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    pix_d   = pix_q;
    ctr_d   = ctr_q;
    stat_d  = stat_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          job_d   = mem_q[rd_ptr_q[PW-1:0]];
          err_d   = E_OK;
          cyc_d   = '0;
          pix_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_desc) begin
          err_d   = E_BAD;
          state_d = S_RESULT;
        end else begin
          state_d = S_WR_SCALE;
        end
      end
      S_WR_SCALE: state_d = S_WR_IN;
      S_WR_IN:    state_d = S_WR_OUT;
      S_WR_OUT:   state_d = S_WR_CTRL;
      S_WR_CTRL: begin
        ctr_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        ctr_d = (ctr_q == '1) ? ctr_q : ctr_q + 32'd1;
        // A DONE seen in the very first poll may be left over from the
        // previous job, so it only counts from the second cycle on.
        if (st_done && (ctr_q != '0)) begin
          state_d = S_WAIT_DONE;
        end else if (abort) begin
          err_d   = E_ABORT;
          state_d = S_RD_CYC;
        end else if (tmo_hit) begin
          err_d   = E_TMO;
          state_d = S_RD_CYC;
        end else if (st_busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        ctr_d = (ctr_q == '1) ? ctr_q : ctr_q + 32'd1;
        if (st_done) begin
          err_d   = E_OK;
          state_d = S_RD_CYC;
        end else if (abort) begin
          err_d   = E_ABORT;
          state_d = S_RD_CYC;
        end else if (tmo_hit) begin
          err_d   = E_TMO;
          state_d = S_RD_CYC;
        end
      end
      S_RD_CYC: begin
        cyc_d   = csr_rdata;
        state_d = S_RD_PIX;
      end
      S_RD_PIX: begin
        pix_d   = csr_rdata;
        state_d = S_DISABLE;
      end
      S_DISABLE: state_d = S_RESULT;
      S_RESULT: begin
        if (res_ready) begin
          if (err_q == E_OK) stat_d = stat_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    csr_we    = 1'b0;
    csr_addr  = init_q ? A_STATUS : 4'd0;
    csr_wdata = '0;
    res_valid = 1'b0;
    unique case (state_q)
      S_WR_SCALE: begin
        csr_we    = 1'b1;
        csr_addr  = A_SCALE;
        csr_wdata = {16'h0, job_q.scale};
      end
      S_WR_IN: begin
        csr_we    = 1'b1;
        csr_addr  = A_IN_WH;
        csr_wdata = {job_q.in_w, job_q.in_h};
      end
      S_WR_OUT: begin
        csr_we    = 1'b1;
        csr_addr  = A_OUT_WH;
        csr_wdata = {job_q.out_w, job_q.out_h};
      end
      S_WR_CTRL: begin
        csr_we    = 1'b1;
        csr_addr  = A_CTRL;
        csr_wdata = {29'h0, job_q.mode, 2'b11};
      end
      S_RD_CYC:  csr_addr = A_PERF_C;
      S_RD_PIX:  csr_addr = A_PERF_P;
      S_DISABLE: begin
        csr_we    = 1'b1;
        csr_addr  = A_CTRL;
        csr_wdata = '0;
      end
      S_RESULT:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_tag    = job_q.tag;
  assign res_err    = err_q;
  assign res_cycles = cyc_q;
  assign res_pixels = pix_q;
  assign stat_jobs  = stat_q;
  assign seq_busy   = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bilinear_job_sequencer.sv
module tb_bilinear_job_sequencer;

  localparam int unsigned TMO = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [3:0]  job_tag = '0;
  logic        job_mode = 1'b0;
  logic [15:0] job_scale_q = '0;
  logic [15:0] job_in_w = '0, job_in_h = '0, job_out_w = '0, job_out_h = '0;
  logic        abort = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [3:0]  res_tag;
  logic [1:0]  res_err;
  logic [31:0] res_cycles, res_pixels;
  logic        seq_busy;
  logic [15:0] stat_jobs;
  logic        csr_we;
  logic [3:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  always #5 clk = ~clk;

  bilinear_job_sequencer #(.QDEPTH(4), .TAG_W(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
    .job_mode(job_mode), .job_scale_q(job_scale_q),
    .job_in_w(job_in_w), .job_in_h(job_in_h),
    .job_out_w(job_out_w), .job_out_h(job_out_h),
    .abort(abort),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_err(res_err), .res_cycles(res_cycles), .res_pixels(res_pixels),
    .seq_busy(seq_busy), .stat_jobs(stat_jobs),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata)
  );

  // Cycle counter: after posedge n the value is n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for bilinear_top's CSR block.
  int          m_len = 300;
  logic        m_hang = 1'b0;
  logic [31:0] m_ctrl, m_scale, m_inwh, m_outwh, m_cyc, m_pix;
  logic        m_busy, m_done;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl <= '0; m_scale <= '0; m_inwh <= '0; m_outwh <= '0;
      m_cyc <= '0; m_pix <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
    end else begin
      if (m_busy && !m_hang) begin
        if (m_cnt <= 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (csr_we) begin
        case (csr_addr)
          4'd0: begin
            m_ctrl <= csr_wdata;
            if (csr_wdata[1:0] == 2'b11) begin
              m_busy <= 1'b1;
              m_done <= 1'b0;
              m_cnt  <= m_len;
              m_cyc  <= 32'(m_len);
              m_pix  <= 32'(m_outwh[31:16]) * 32'(m_outwh[15:0]);
            end else if (!csr_wdata[0]) begin
              m_busy <= 1'b0;
            end
          end
          4'd2: m_scale <= csr_wdata;
          4'd3: m_inwh  <= csr_wdata;
          4'd4: m_outwh <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (csr_addr)
      4'd0:    csr_rdata = m_ctrl;
      4'd1:    csr_rdata = {30'h0, m_done, m_busy};
      4'd2:    csr_rdata = m_scale;
      4'd3:    csr_rdata = m_inwh;
      4'd4:    csr_rdata = m_outwh;
      4'd5:    csr_rdata = m_cyc;
      4'd6:    csr_rdata = m_pix;
      default: csr_rdata = 32'h0;
    endcase
  end

  // Scoreboard and logs
  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  err;
    logic [31:0] cycles;
    logic [31:0] pixels;
  } res_t;

  res_t        sbq[$];
  logic [3:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          n_checks = 0, n_errors = 0;
  int          n_res = 0, exp_stat = 0;
  int          rv_cyc = 0, done_cyc = 0, push_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic rv_prev = 1'b0, dn_prev = 1'b0;
    res_t e;
    forever begin
      @(negedge clk);
      if (csr_we) begin
        wq_addr.push_back(csr_addr);
        wq_data.push_back(csr_wdata);
        wq_cyc.push_back(cyc);
      end
      if (res_valid && !rv_prev) rv_cyc = cyc;
      if (m_done && !dn_prev) done_cyc = cyc;
      rv_prev = res_valid;
      dn_prev = m_done;
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) begin
          check_eq("sb_unexpected_result", {60'h0, res_tag}, 64'hFFFF);
        end else begin
          e = sbq.pop_front();
          check_eq("res_tag", res_tag, e.tag);
          check_eq("res_err", res_err, e.err);
          check_eq("res_cycles", res_cycles, e.cycles);
          check_eq("res_pixels", res_pixels, e.pixels);
          if (e.err == 2'd0) exp_stat++;
        end
        n_res++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the push edge.
  task automatic push_job(input logic [3:0] tag, input logic mode, input logic [15:0] sc,
                          input logic [15:0] iw, input logic [15:0] ih,
                          input logic [15:0] ow, input logic [15:0] oh,
                          input logic [1:0] eerr, input bit expect_res);
    res_t e;
    int   k = 0;
    job_tag = tag; job_mode = mode; job_scale_q = sc;
    job_in_w = iw; job_in_h = ih; job_out_w = ow; job_out_h = oh;
    job_valid = 1'b1;
    while (!job_ready && k < 2000) begin tick(); k++; end
    if (!job_ready) check_eq("push_ready_timeout", 0, 1);
    tick();
    push_cyc  = cyc;
    job_valid = 1'b0;
    if (expect_res) begin
      e.tag = tag;
      e.err = eerr;
      if (eerr == 2'd1) begin
        e.cycles = 32'h0;
        e.pixels = 32'h0;
      end else begin
        e.cycles = 32'(m_len);
        e.pixels = 32'(ow) * 32'(oh);
      end
      sbq.push_back(e);
    end
  endtask

  task automatic wait_res(input int target, input int budget);
    int k = 0;
    while (n_res < target && k < budget) begin tick(); k++; end
    if (n_res < target) check_eq("wait_res_timeout", n_res, target);
  endtask

  function automatic int ctrl_start_cyc();
    ctrl_start_cyc = -1;
    foreach (wq_addr[i])
      if (wq_addr[i] == 4'd0 && wq_data[i] != 32'h0 && ctrl_start_cyc < 0)
        ctrl_start_cyc = wq_cyc[i];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  exp_a[5];
    logic [31:0] exp_d[5];
    int          base, k, c0;

    fork monitor(); join_none

    // Reset state
    #12;
    check_eq("rst_job_ready", job_ready, 1);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_seq_busy", seq_busy, 0);
    check_eq("rst_csr_we", csr_we, 0);
    check_eq("rst_csr_addr", csr_addr, 0);
    check_eq("rst_stat", stat_jobs, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check_eq("idle_csr_addr", csr_addr, 1);

    // 1: nominal SIMD job
    clear_log();
    m_len = 300;
    push_job(4'd3, 1'b1, 16'h0200, 16'd64, 16'd64, 16'd32, 16'd32, 2'd0, 1'b1);
    base = push_cyc;
    wait_res(1, 1000);
    exp_a = '{4'd2, 4'd3, 4'd4, 4'd0, 4'd0};
    exp_d = '{32'h0000_0200, 32'h0040_0040, 32'h0020_0020, 32'h0000_0007, 32'h0};
    check_eq("t1_nwrites", wq_addr.size(), 5);
    if (wq_addr.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check_eq($sformatf("t1_waddr%0d", i), wq_addr[i], exp_a[i]);
        check_eq($sformatf("t1_wdata%0d", i), wq_data[i], exp_d[i]);
      end
    end
    check_eq("t1_ctrl_latency", ctrl_start_cyc() - base, 5);
    check_eq("t1_result_latency", rv_cyc - done_cyc, 4);
    check_eq("t1_stat", stat_jobs, 1);

    // 2: bad descriptor then valid one; only the valid job touches CSRs
    clear_log();
    m_len = 40;
    push_job(4'd1, 1'b0, 16'h0100, 16'd16, 16'd16, 16'd0, 16'd8, 2'd1, 1'b1);
    push_job(4'd2, 1'b0, 16'h0180, 16'd48, 16'd24, 16'd32, 16'd16, 2'd0, 1'b1);
    wait_res(3, 500);
    check_eq("t2_nwrites", wq_addr.size(), 5);
    if (wq_addr.size() > 0) check_eq("t2_first_waddr", wq_addr[0], 2);

    // 3: core never finishes -> timeout
    clear_log();
    m_hang = 1'b1;
    m_len  = 77;
    push_job(4'd5, 1'b0, 16'h0100, 16'd8, 16'd8, 16'd8, 16'd8, 2'd2, 1'b1);
    wait_res(4, TMO + 200);
    m_hang = 1'b0;
    check_eq("t3_tmo_latency", rv_cyc - ctrl_start_cyc(), TMO + 5);
    if (wq_addr.size() > 0) begin
      check_eq("t3_last_waddr", wq_addr[wq_addr.size()-1], 0);
      check_eq("t3_last_wdata", wq_data[wq_addr.size()-1], 0);
    end

    // 4: five back-to-back jobs with results stalled
    res_ready = 1'b0;
    m_len = 10;
    for (int i = 0; i < 5; i++)
      push_job(4'(8 + i), i[0], 16'h0100, 16'd20, 16'd10, 16'(2 + i), 16'd3, 2'd0, 1'b1);
    check_eq("t4_full_ready", job_ready, 0);
    repeat (60) tick();
    check_eq("t4_held_valid", res_valid, 1);
    check_eq("t4_held_tag", res_tag, 8);
    check_eq("t4_busy", seq_busy, 1);
    check_eq("t4_no_accept", n_res, 4);
    res_ready = 1'b1;
    wait_res(9, 400);
    tick();
    check_eq("t4_ready_after", job_ready, 1);
    check_eq("t4_idle_after", seq_busy, 0);

    // 5a: abort during WAIT_DONE
    clear_log();
    m_len = 300;
    push_job(4'd6, 1'b1, 16'h0100, 16'd32, 16'd32, 16'd16, 16'd16, 2'd3, 1'b1);
    k = 0;
    while (wq_addr.size() < 4 && k < 100) begin tick(); k++; end
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_res(10, 100);
    check_eq("t5_nwrites", wq_addr.size(), 5);
    if (wq_addr.size() == 5) begin
      check_eq("t5_dis_addr", wq_addr[4], 0);
      check_eq("t5_dis_data", wq_data[4], 0);
    end

    // 5b: abort while in WR_IN is ignored
    m_len = 20;
    push_job(4'd7, 1'b0, 16'h0100, 16'd12, 16'd12, 16'd6, 16'd6, 2'd0, 1'b1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_res(11, 200);
    tick();
    check_eq("stat_total", stat_jobs, exp_stat);

    // 6: reset mid-job
    m_len = 300;
    push_job(4'd9, 1'b0, 16'h0100, 16'd40, 16'd40, 16'd20, 16'd20, 2'd0, 1'b0);
    repeat (30) tick();
    c0 = n_res;
    rst_n = 1'b0;
    #1;
    check_eq("t6_res_valid", res_valid, 0);
    check_eq("t6_job_ready", job_ready, 1);
    check_eq("t6_seq_busy", seq_busy, 0);
    check_eq("t6_csr_we", csr_we, 0);
    check_eq("t6_csr_addr", csr_addr, 0);
    check_eq("t6_csr_wdata", csr_wdata, 0);
    check_eq("t6_res_fields", {res_tag, res_err, res_cycles, res_pixels}, 0);
    check_eq("t6_stat", stat_jobs, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check_eq("t6_no_result", n_res, c0);
    check_eq("t6_idle", seq_busy, 0);
    check_eq("t6_poll_addr", csr_addr, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
